// File: rtl/hll_pkg.sv
// Shared HyperLogLog constants and types, used by the splitter, this bucket stage and the estimator.
package hll_pkg;

    localparam int IDX_W       = 14;
    localparam int RANK_W      = 5;
    localparam int NUM_BUCKETS = 2 ** IDX_W;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [RANK_W-1:0] rank_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        FLUSH,
        DRAIN
    } state_e;

    // One drained register value, tagged with end-of-frame
    typedef struct packed {
        logic  last;
        rank_t data;
    } beat_t;

    function automatic rank_t rank_max(input rank_t a, input rank_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hll_bucket_update_if.sv
// Element stream in, drained register stream out, plus the busy status.
interface hll_bucket_update_if;
    import hll_pkg::*;

    idx_t  in_index;
    rank_t in_rank;
    logic  in_valid;
    logic  in_last;
    logic  in_ready;

    rank_t out_data;
    logic  out_valid;
    logic  out_last;
    logic  out_ready;

    logic  busy;

    modport slave (
        input  in_index, in_rank, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );

    modport master (
        output in_index, in_rank, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

endinterface

// File: rtl/hll_reg_ram.sv
// Bucket register file: simple dual-port, read-first, one-cycle registered read, contents unreset.
module hll_reg_ram
    import hll_pkg::*;
(
    input  logic  clk,
    input  logic  we_i,
    input  idx_t  waddr_i,
    input  rank_t wdata_i,
    input  idx_t  raddr_i,
    output rank_t rdata_o
);

    rank_t mem_q [NUM_BUCKETS];
    rank_t rdata_q;

    // Read and write share one block so a same-address read returns the old value
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hll_bucket_update.sv
// Per-bucket max-rank register file with RMW forwarding; drains and zeroes all buckets after each frame.
module hll_bucket_update
    import hll_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hll_bucket_update_if.slave bus
);

    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    state_e          state_q;
    logic [IDX_W:0]  cnt_q;
    logic            in_ready_q;
    logic            busy_q;

    logic            s1_vld_q;
    idx_t            s1_idx_q;
    rank_t           s1_rank_q;
    logic            fw_vld_q;
    idx_t            fw_idx_q;
    rank_t           fw_data_q;

    logic            infl_q;
    logic            infl_last_q;
    beat_t [1:0]     buf_q, buf_d;
    logic [1:0]      buf_cnt_q, buf_cnt_d;

    logic            accept;
    logic            pop;
    logic            issue;
    logic            drain_done;
    idx_t            cnt_idx;
    rank_t           old_rank;
    rank_t           new_rank;

    logic            ram_we;
    idx_t            ram_waddr;
    idx_t            ram_raddr;
    rank_t           ram_wdata;
    rank_t           ram_rdata;

    assign cnt_idx    = cnt_q[IDX_W-1:0];
    assign accept     = bus.in_valid && in_ready_q;

    // The RAM read misses the write retiring this cycle; take that value instead
    assign old_rank   = (fw_vld_q && (fw_idx_q == s1_idx_q)) ? fw_data_q : ram_rdata;
    assign new_rank   = rank_max(old_rank, s1_rank_q);

    assign pop        = (buf_cnt_q != 2'd0) && bus.out_ready;
    // Never issue more reads than the buffer can hold once they land
    assign issue      = (state_q == DRAIN) && !cnt_q[IDX_W] &&
                        (((buf_cnt_q + {1'b0, infl_q}) < 2'd2) || pop);
    assign drain_done = pop && buf_q[0].last;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_idx_q;
        ram_wdata = new_rank;
        ram_raddr = bus.in_index;
        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_idx;
                ram_wdata = '0;
            end
            DRAIN: begin
                ram_raddr = cnt_idx;
                ram_we    = issue;
                ram_waddr = cnt_idx;
                ram_wdata = '0;
            end
            default: ram_we = s1_vld_q;
        endcase
    end

    always_comb begin
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        if (pop) begin
            buf_d[0]  = buf_q[1];
            buf_d[1]  = '0;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (infl_q) begin
            if (buf_cnt_d == 2'd0) begin
                buf_d[0] = '{last: infl_last_q, data: ram_rdata};
            end else begin
                buf_d[1] = '{last: infl_last_q, data: ram_rdata};
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_rank_q   <= '0;
            fw_vld_q    <= 1'b0;
            fw_idx_q    <= '0;
            fw_data_q   <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            buf_q       <= '0;
            buf_cnt_q   <= 2'd0;
        end else begin
            s1_vld_q    <= accept;
            s1_idx_q    <= bus.in_index;
            s1_rank_q   <= bus.in_rank;
            fw_vld_q    <= s1_vld_q;
            fw_idx_q    <= s1_idx_q;
            fw_data_q   <= new_rank;
            infl_q      <= issue;
            infl_last_q <= issue && (&cnt_idx);
            buf_q       <= buf_d;
            buf_cnt_q   <= buf_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (&cnt_idx) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (accept && bus.in_last) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (issue) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    // Drain left every bucket at zero, so no CLEAR pass is needed
                    if (drain_done) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    hll_reg_ram u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = (buf_cnt_q != 2'd0);
    assign bus.out_data  = buf_q[0].data;
    assign bus.out_last  = buf_q[0].last && (buf_cnt_q != 2'd0);

endmodule

// File: tb/tb_hll_bucket_update.sv
// Scoreboard bench: a per-bucket max model fills the expected drain queue; a monitor checks each beat.
module tb_hll_bucket_update;
    import hll_pkg::*;

    typedef struct {
        bit                last;
        logic [RANK_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    hll_bucket_update_if bus();

    hll_bucket_update dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_pass;
    int   beat_cnt;
    bit   rdy_rand;
    int   model [NUM_BUCKETS];
    exp_t exp_q [$];

    bit                st_prev;
    bit                st_last;
    logic [RANK_W-1:0] st_data;

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability
    always @(negedge clk) begin
        if (rst) begin
            st_prev = 1'b0;
        end else begin
            if (st_prev)
                chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, st_last, st_data});
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", beat_cnt), {bus.out_last, bus.out_data}, {e.last, e.data});
                end
                beat_cnt++;
            end
            st_prev = bus.out_valid && !bus.out_ready;
            st_last = bus.out_last;
            st_data = bus.out_data;
        end
    end

    // out_ready: random 50% over the head and tail of a drain when enabled
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_rand && (beat_cnt < 4096 || beat_cnt >= NUM_BUCKETS - 1024))
                bus.out_ready = ($urandom_range(0, 1) == 1);
            else
                bus.out_ready = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_last"},  bus.out_last,  0);
        chk({tag, "_out_data"},  bus.out_data,  0);
        chk({tag, "_busy"},      bus.busy,      1);
    endtask

    task automatic check_clear();
        int bad;
        bad = 0;
        for (int k = 1; k < NUM_BUCKETS; k++) begin
            @(posedge clk); #1;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) bad++;
        end
        chk("clear_window_bad_cycles", bad, 0);
        @(posedge clk); #1;
        chk("clear_done_in_ready", bus.in_ready, 1);
        chk("clear_done_busy", bus.busy, 0);
    endtask

    // Called just after a clock edge; returns just after the accepting edge
    task automatic send(input int idx, input int rank, input bit last);
        bus.in_valid = 1'b1;
        bus.in_index = idx_t'(idx);
        bus.in_rank  = rank_t'(rank);
        bus.in_last  = last;
        chk("in_ready_run", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (rank > model[idx]) model[idx] = rank;
        if (last) begin
            for (int i = 0; i < NUM_BUCKETS; i++) begin
                exp_t e;
                e.last = (i == NUM_BUCKETS - 1);
                e.data = model[i][RANK_W-1:0];
                exp_q.push_back(e);
                model[i] = 0;
            end
        end
    endtask

    task automatic post_last(input bit junk);
        chk("in_ready_fall", bus.in_ready, 0);
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_index = idx_t'(9);
            bus.in_rank  = rank_t'(31);
            bus.in_last  = 1'b1;
        end
        idle(2);
        chk("first_valid_early", bus.out_valid, 0);
        idle(1);
        chk("first_valid", bus.out_valid, 1);
        if (junk) begin
            idle(8);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60000; t++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        chk("drain_complete_left", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("rearm_in_ready", bus.in_ready, 1);
        chk("rearm_busy", bus.busy, 0);
        chk("rearm_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        int idx;
        n_chk = 0; n_pass = 0; beat_cnt = 0; rdy_rand = 1'b0; st_prev = 1'b0;
        for (int i = 0; i < NUM_BUCKETS; i++) model[i] = 0;
        bus.in_valid = 1'b0; bus.in_index = '0; bus.in_rank = '0; bus.in_last = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 reset_checks("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_clear();

        // Frame A: random traffic, same-index bursts, stalled drain, junk input while busy
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) idx = $urandom_range(10, 17);
            else                           idx = $urandom_range(100, 16000);
            send(idx, $urandom_range(0, 31), 1'b0);
            idle($urandom_range(0, 2));
        end
        send(5, 3, 1'b0);
        send(5, 7, 1'b0);
        send(5, 2, 1'b0);
        beat_cnt = 0;
        send(NUM_BUCKETS - 1, 19, 1'b1);
        post_last(1'b1);
        wait_drain();
        rdy_rand = 1'b0;

        // Frame B: everything, including 5, 9 and the top bucket, must drain as zero
        beat_cnt = 0;
        send(0, 0, 1'b1);
        post_last(1'b0);
        wait_drain();

        // Frame C: reset in the middle of the drain
        send(2, 6, 1'b0);
        beat_cnt = 0;
        send(3, 8, 1'b1);
        post_last(1'b0);
        for (int t = 0; t < 1000; t++) begin
            @(posedge clk); #1;
            if (beat_cnt >= 100) break;
        end
        chk("reached_beat100", int'(beat_cnt >= 100), 1);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_BUCKETS; i++) model[i] = 0;
        #1 reset_checks("mid_drain_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_clear();

        // Frame D: fresh frame after reset
        beat_cnt = 0;
        send(1, 4, 1'b1);
        post_last(1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
